// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates the single piezo tone generator between the
// alarm melody, the sleep lullaby and a counted one-shot key-click tone.
// Fixed priority alarm > click > lullaby, with a silent gap on every hand-over.
//
// Ports:
//   clock         system clock
//   reset         asynchronous active-high reset
//   alarm_beat    beat code from the alarm sequencer (0 = silence)
//   alarm_req     level, alarm wants the piezo
//   lullaby_beat  beat code from the lullaby sequencer
//   lullaby_req   level, lullaby wants the piezo
//   click         single-cycle key-press pulse
//   mute          level, forces silence without touching arbitration
//   play_sound    registered beat code to the piezo driver
//   grant         registered owner: 0 none/gap, 1 lullaby, 2 click, 3 alarm
//   busy          registered, high whenever not IDLE
module sound_scheduler #(
  parameter int unsigned CLICK_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES   = 1000000,
  parameter logic [12:0] CLICK_NOTE   = 13'd40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [12:0] alarm_beat,
  input  logic        alarm_req,
  input  logic [12:0] lullaby_beat,
  input  logic        lullaby_req,
  input  logic        click,
  input  logic        mute,
  output logic [12:0] play_sound,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned MAX_CYC = (CLICK_CYCLES > GAP_CYCLES) ? CLICK_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CLICK_LOAD = CNT_W'(CLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY_ALARM,
    S_PLAY_CLICK,
    S_PLAY_LULL,
    S_GAP
  } state_t;

  state_t           state, state_next, win;
  logic             click_pend;
  logic             click_req;
  logic [CNT_W-1:0] click_cnt, gap_cnt;
  logic [12:0]      sound_next;
  logic [1:0]       grant_next;

  // A fresh click counts as a request in its own cycle so it can win in IDLE;
  // it is ignored while the alarm plays and only retriggers a running click.
  assign click_req = click_pend |
                     (click & (state != S_PLAY_ALARM) & (state != S_PLAY_CLICK));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and next-output logic
  always_comb begin
    win        = S_IDLE;
    state_next = state;
    grant_next = 2'd0;
    sound_next = 13'd0;

    if (alarm_req)        win = S_PLAY_ALARM;
    else if (click_req)   win = S_PLAY_CLICK;
    else if (lullaby_req) win = S_PLAY_LULL;

    case (state)
      S_IDLE:       state_next = win;
      S_PLAY_ALARM: if (!alarm_req) state_next = S_GAP;
      S_PLAY_LULL:  if (!lullaby_req || alarm_req || click_req) state_next = S_GAP;
      // A retrigger in the last cycle keeps the click alive.
      S_PLAY_CLICK: if (alarm_req || (!click && click_cnt == '0)) state_next = S_GAP;
      S_GAP:        if (gap_cnt == '0) state_next = win;
      default:      state_next = S_IDLE;
    endcase

    case (state_next)
      S_PLAY_ALARM: begin grant_next = 2'd3; sound_next = alarm_beat;   end
      S_PLAY_CLICK: begin grant_next = 2'd2; sound_next = CLICK_NOTE;   end
      S_PLAY_LULL:  begin grant_next = 2'd1; sound_next = lullaby_beat; end
      default:      ;
    endcase

    if (mute) sound_next = 13'd0;
  end

  // Registered outputs, pending click and the two hold-at-zero counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      play_sound <= 13'd0;
      grant      <= 2'd0;
      busy       <= 1'b0;
      click_pend <= 1'b0;
      click_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      play_sound <= sound_next;
      grant      <= grant_next;
      busy       <= (state_next != S_IDLE);

      // Pending click is consumed on entry; a click losing to the alarm is dropped.
      if (state_next == S_PLAY_CLICK)
        click_pend <= 1'b0;
      else if (click && state != S_PLAY_ALARM && state != S_PLAY_CLICK &&
               state_next != S_PLAY_ALARM)
        click_pend <= 1'b1;

      if (state_next == S_PLAY_CLICK) begin
        if (state != S_PLAY_CLICK || click) click_cnt <= CLICK_LOAD;
        else if (click_cnt != '0)           click_cnt <= click_cnt - CNT_W'(1);
      end else begin
        click_cnt <= '0;
      end

      if (state_next == S_GAP) begin
        if (state != S_GAP)       gap_cnt <= GAP_LOAD;
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - CNT_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Testbench for sound_scheduler with CLICK_CYCLES=8, GAP_CYCLES=4.
// Expected {grant, play_sound, busy} words are queued as stimulus is planned
// and popped once per clock as the DUT produces them.
module tb_sound_scheduler;

  logic        clock;
  logic        reset;
  logic [12:0] alarm_beat;
  logic        alarm_req;
  logic [12:0] lullaby_beat;
  logic        lullaby_req;
  logic        click;
  logic        mute;
  logic [12:0] play_sound;
  logic [1:0]  grant;
  logic        busy;

  typedef struct packed {
    logic [1:0]  g;
    logic [12:0] ps;
    logic        b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  sound_scheduler #(
    .CLICK_CYCLES(8),
    .GAP_CYCLES  (4),
    .CLICK_NOTE  (13'd40)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alarm_beat  (alarm_beat),
    .alarm_req   (alarm_req),
    .lullaby_beat(lullaby_beat),
    .lullaby_req (lullaby_req),
    .click       (click),
    .mute        (mute),
    .play_sound  (play_sound),
    .grant       (grant),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [1:0] g, input logic [12:0] ps, input logic b);
    exp_t e;
    e.g = g; e.ps = ps; e.b = b;
    return e;
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    alarm_beat = 13'd0; alarm_req = 1'b0;
    lullaby_beat = 13'd0; lullaby_req = 1'b0;
    click = 1'b0; mute = 1'b0;
    repeat (3) tick();
    checks++;
    if (play_sound !== 13'd0) begin errors++; $display("FAIL reset_play_sound: got %0d want 0", play_sound); end
    checks++;
    if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    reset = 1'b0;
    q.push_back(mk(2'd0, 13'd0, 1'b0));
    tick();
    e = q.pop_front();
    checks++;
    if ({grant, play_sound, busy} !== e) begin
      errors++;
      $display("FAIL reset_idle: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
               grant, play_sound, busy, e.g, e.ps, e.b);
    end
  endtask

  task automatic test_lullaby();
    exp_t e;
    q.push_back(mk(2'd1, 13'd120, 1'b1));
    q.push_back(mk(2'd1, 13'd120, 1'b1));
    q.push_back(mk(2'd1, 13'd121, 1'b1));
    q.push_back(mk(2'd1, 13'd120, 1'b1));
    lullaby_req = 1'b1; lullaby_beat = 13'd120;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) lullaby_beat = 13'd121;
      if (i == 4) lullaby_beat = 13'd120;
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL lullaby cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
  endtask

  // Click preempts the lullaby: gap, full click, gap, lullaby again.
  task automatic test_click_preempt();
    exp_t e;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 4 || i >= 13 && i <= 16) q.push_back(mk(2'd0, 13'd0, 1'b1));
      else if (i <= 12)                  q.push_back(mk(2'd2, 13'd40, 1'b1));
      else                               q.push_back(mk(2'd1, 13'd120, 1'b1));
    end
    click = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      click = 1'b0;
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL click_preempt cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
  endtask

  // Alarm preempts a running click; the click is not resumed.
  task automatic test_alarm_preempt();
    exp_t e;
    for (int i = 1; i <= 13; i++) begin
      if (i <= 4 || i >= 8 && i <= 11) q.push_back(mk(2'd0, 13'd0, 1'b1));
      else if (i <= 7)                  q.push_back(mk(2'd2, 13'd40, 1'b1));
      else                              q.push_back(mk(2'd3, 13'd300, 1'b1));
    end
    click = 1'b1; lullaby_req = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 8) begin alarm_req = 1'b1; alarm_beat = 13'd300; end
      tick();
      click = 1'b0;
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL alarm_preempt cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
  endtask

  // Clicks during the alarm are discarded; alarm drop leads to gap then idle.
  task automatic test_alarm_discards_click();
    exp_t e;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 2)       q.push_back(mk(2'd3, 13'd300, 1'b1));
      else if (i <= 6)  q.push_back(mk(2'd3, 13'd301, 1'b1));
      else if (i <= 10) q.push_back(mk(2'd0, 13'd0, 1'b1));
      else              q.push_back(mk(2'd0, 13'd0, 1'b0));
    end
    for (int i = 1; i <= 12; i++) begin
      click = (i == 1 || i == 3 || i == 5);
      alarm_req = (i < 7);
      if (i == 3) alarm_beat = 13'd301;
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL alarm_discards_click cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
    click = 1'b0;
  endtask

  // Click beats lullaby in IDLE; retrigger at counter=2 extends by 8 cycles.
  task automatic test_retrigger();
    exp_t e;
    for (int i = 1; i <= 19; i++) begin
      if (i <= 14)      q.push_back(mk(2'd2, 13'd40, 1'b1));
      else if (i <= 18) q.push_back(mk(2'd0, 13'd0, 1'b1));
      else              q.push_back(mk(2'd1, 13'd200, 1'b1));
    end
    lullaby_beat = 13'd200; lullaby_req = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      click = (i == 1 || i == 7);
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL retrigger cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
    click = 1'b0;
  endtask

  // Mute silences only play_sound; reset mid-play and mid-gap silences at once.
  task automatic test_mute_reset();
    exp_t e;
    q.push_back(mk(2'd1, 13'd0, 1'b1));
    q.push_back(mk(2'd1, 13'd0, 1'b1));
    q.push_back(mk(2'd1, 13'd200, 1'b1));
    for (int i = 1; i <= 3; i++) begin
      mute = (i < 3);
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL mute cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, play_sound, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_play: got grant=%0d play_sound=%0d busy=%0b want all 0", grant, play_sound, busy);
    end
    reset = 1'b0;
    q.push_back(mk(2'd1, 13'd200, 1'b1));
    q.push_back(mk(2'd0, 13'd0, 1'b1));
    q.push_back(mk(2'd0, 13'd0, 1'b1));
    for (int i = 1; i <= 3; i++) begin
      lullaby_req = (i == 1);
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL after_reset cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 2'd0 || play_sound !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_gap: got grant=%0d play_sound=%0d busy=%0b want all 0", grant, play_sound, busy);
    end
    reset = 1'b0;
    q.push_back(mk(2'd0, 13'd0, 1'b0));
    q.push_back(mk(2'd0, 13'd0, 1'b0));
    for (int i = 1; i <= 2; i++) begin
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL idle_after_gap_reset cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
  endtask

  // Click and alarm together in IDLE: alarm wins, click is not queued.
  task automatic test_click_alarm_tie();
    exp_t e;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 2)      q.push_back(mk(2'd3, 13'd300, 1'b1));
      else if (i <= 6) q.push_back(mk(2'd0, 13'd0, 1'b1));
      else             q.push_back(mk(2'd0, 13'd0, 1'b0));
    end
    alarm_beat = 13'd300;
    for (int i = 1; i <= 8; i++) begin
      click = (i == 1);
      alarm_req = (i <= 2);
      tick();
      e = q.pop_front();
      checks++;
      if ({grant, play_sound, busy} !== e) begin
        errors++;
        $display("FAIL click_alarm_tie cycle %0d: got grant=%0d play_sound=%0d busy=%0b want grant=%0d play_sound=%0d busy=%0b",
                 i, grant, play_sound, busy, e.g, e.ps, e.b);
      end
    end
    click = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lullaby();
    test_click_preempt();
    test_alarm_preempt();
    test_alarm_discards_click();
    test_retrigger();
    test_mute_reset();
    test_click_alarm_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
